seqdet_ctrl: RTL and testbench
==============================

SEQDET_CTRL -- requirements
Module: seqdet_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, is the width of each parallel input word, serialized MSB first.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset is synchronous and active-high.
REQ-004 cfg_we  input  1  Configuration write strobe; honoured only in IDLE.
REQ-005 cfg_pattern  input  8  Pattern to detect, right-aligned; the last-received bit compares to bit 0.
REQ-006 cfg_len  input  4  Pattern length in bits: 0 disables detection; values above 8 are clamped to 8.
REQ-007 cfg_thresh  input  8  Match count that raises irq; 0 disables irq.
REQ-008 in_valid  input  1  Parallel word offered.
REQ-009 in_data  input  DATA_W  Parallel word.
REQ-010 in_ready  output  1  Block accepts a word this cycle; transfer occurs when in_valid&&in_ready.
REQ-011 bit_valid  output  1  bit_out carries a stream bit this cycle.
REQ-012 bit_out  output  1  Serialized stream bit.
REQ-013 match  output  1  One-cycle pulse: pattern completed by the previous stream bit.
REQ-014 match_cnt  output  8  Matches since last config write or reset; saturates at 255.
REQ-015 irq  output  1  Sticky threshold interrupt.
REQ-016 irq_clr  input  1  Clears irq.
REQ-017 busy  output  1  High while in SHIFT.

Function
REQ-018 The FSM SHALL have two states: IDLE (no word pending) and SHIFT (serializing a word).
- Transitions: IDLE->SHIFT on an accepted word. In SHIFT, with bit index 0 as the current bit: an accepted word stays in SHIFT; otherwise the FSM goes to IDLE.
REQ-019 in_ready SHALL be 1 in IDLE and in the SHIFT cycle presenting bit index 0, else 0.
- Consequence: back-to-back words stream with no gap.
REQ-020 A word accepted in cycle T SHALL present bit DATA_W-1 in T+1 through bit 0 in T+DATA_W.
- bit_valid is 1 in each of those cycles.
- bit_out and bit_valid are registered outputs.
REQ-021 In IDLE, bit_valid SHALL be 0 and bit_out SHALL hold 0.
REQ-022 A history register SHALL shift in each stream bit when bit_valid=1.
- A fill counter saturating at 8 tracks how many bits have been received.
- History and fill counter persist across words, so patterns may span word boundaries.
REQ-023 When a stream bit is emitted, detection SHALL occur if all of these hold:
- effective len > 0;
- fill including that bit >= len;
- the low len history bits including that bit equal cfg_pattern[len-1:0].
On detection, match=1 in the following cycle. Overlapping matches count.
REQ-024 match_cnt SHALL increment in the same cycle match is 1, saturating at 255.
REQ-025 irq SHALL set in the cycle match_cnt becomes equal to a nonzero cfg_thresh.
- irq holds until irq_clr=1.
- If set and clear occur in the same cycle, set wins.
REQ-026 A cfg_we in IDLE SHALL, on that edge, latch pattern, len and thresh, and clear history, fill, match_cnt and irq.
- cfg_we in SHIFT is ignored with no side effects.
- cfg_we together with an accepted word in IDLE: the config is applied first, then the word starts.
REQ-027 in_data SHALL be captured only on transfer; in_data changes while not ready have no effect.

Reset
REQ-028 With rst=1 at an edge, the block SHALL reset as follows:
- FSM to IDLE, so in_ready=1 on the next cycle;
- bit_valid=0, bit_out=0, match=0, match_cnt=0, irq=0, busy=0;
- history=0, fill=0;
- pattern=8'h12, len=5 (pattern 10010), thresh=0.
REQ-029 Reset SHALL override all other inputs, including mid-word.
- A partially shifted word is discarded and no further bits of it are emitted.

Verification
REQ-030 Default config, word 8'b1001_0010 accepted at T -> bits 1,0,0,1,0,0,1,0 in T+1..T+8; match at T+6 and T+9; match_cnt=2.
REQ-031 Words 8'hFF and 8'h00 offered continuously -> in_ready=1 at T+8; bit_valid stays 1 for 16 cycles with no gap; busy=1 throughout.
REQ-032 Config pattern=8'h01, len=1, thresh=3, then word 8'h07 -> match at T+7, T+8, T+9; irq=1 from T+9; irq_clr at T+9 -> irq stays 1; irq_clr at T+10 -> irq=0 at T+11.
REQ-033 Default config, word 8'h09 then 8'h00 back-to-back -> the cross-boundary pattern 1,0,0,1,0 matches once, with match the cycle after the first bit of word 2.
REQ-034 cfg_we asserted during SHIFT -> config unchanged; match_cnt unchanged; stream unaffected.
REQ-035 rst asserted at T+3 of a word -> bit_valid=0 from T+4; match_cnt=0; in_ready=1; defaults restored.

Source files
------------

// File: rtl/seqdet_ctrl_if.sv
// Parallel word handshake into seqdet_ctrl: the producer offers in_data with
// in_valid, and the detector accepts it with in_ready.
interface seqdet_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/seqdet_ctrl.sv
// Serializes parallel words MSB first and detects a configurable bit pattern
// across the stream, counting matches and raising a sticky threshold interrupt.
module seqdet_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  seqdet_ctrl_if.slave        in_if,
  input  logic                cfg_we,
  input  logic [7:0]          cfg_pattern,
  input  logic [3:0]          cfg_len,
  input  logic [7:0]          cfg_thresh,
  output logic                bit_valid,
  output logic                bit_out,
  output logic                match,
  output logic [7:0]          match_cnt,
  output logic                irq,
  input  logic                irq_clr,
  output logic                busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_out_q, bit_out_d;
  logic [7:0]        pat_q, pat_d;
  logic [3:0]        len_q, len_d;
  logic [7:0]        thr_q, thr_d;
  logic [7:0]        hist_q, hist_d;
  logic [3:0]        fill_q, fill_d;
  logic              match_q, match_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              irq_q, irq_d;

  logic              in_ready_s;
  logic              accept_s;
  logic [7:0]        mask_s;
  logic              irq_set_s;

  // Ready while idle or while the last bit of the current word is on the wire.
  assign in_ready_s     = (state_q == ST_IDLE) || (idx_q == {IDX_W{1'b0}});
  assign accept_s       = in_if.in_valid && in_ready_s;
  assign in_if.in_ready = in_ready_s;

  // Next-state, serializer, detector, counter and configuration logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bit_valid_d = 1'b0;
    bit_out_d   = 1'b0;
    pat_d       = pat_q;
    len_d       = len_q;
    thr_d       = thr_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = 1'b0;
    cnt_d       = cnt_q;
    irq_d       = irq_q;
    irq_set_s   = 1'b0;
    mask_s      = 8'hFF >> (4'd8 - len_q);

    // The bit currently on the wire enters the history at this edge.
    if (bit_valid_q) begin
      hist_d  = {hist_q[6:0], bit_out_q};
      fill_d  = (fill_q == 4'd8) ? 4'd8 : (fill_q + 4'd1);
      match_d = (len_q != 4'd0) && (fill_d >= len_q) &&
                (((hist_d ^ pat_q) & mask_s) == 8'h00);
    end else begin
      hist_d  = hist_q;
      fill_d  = fill_q;
    end

    if (match_d && (cnt_q != 8'hFF)) begin
      cnt_d     = cnt_q + 8'd1;
      irq_set_s = (thr_q != 8'd0) && (cnt_d == thr_q);
    end else begin
      cnt_d     = cnt_q;
    end

    if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    // Reconfiguration only between words; it wipes detection state.
    if (cfg_we && (state_q == ST_IDLE)) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > 4'd8) ? 4'd8 : cfg_len;
      thr_d  = cfg_thresh;
      hist_d = 8'h00;
      fill_d = 4'd0;
      cnt_d  = 8'd0;
      irq_d  = 1'b0;
    end else begin
      pat_d  = pat_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_SHIFT;
          idx_d       = LAST_IDX;
          bit_valid_d = 1'b1;
          bit_out_d   = in_if.in_data[DATA_W-1];
          word_d      = in_if.in_data << 1;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (idx_q != {IDX_W{1'b0}}) begin
          idx_d       = idx_q - IDX_W'(1);
          bit_valid_d = 1'b1;
          bit_out_d   = word_q[DATA_W-1];
          word_d      = word_q << 1;
        end else if (accept_s) begin
          idx_d       = LAST_IDX;
          bit_valid_d = 1'b1;
          bit_out_d   = in_if.in_data[DATA_W-1];
          word_d      = in_if.in_data << 1;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset to the default detection setup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      word_q      <= {DATA_W{1'b0}};
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      pat_q       <= 8'h12;
      len_q       <= 4'd5;
      thr_q       <= 8'd0;
      hist_q      <= 8'h00;
      fill_q      <= 4'd0;
      match_q     <= 1'b0;
      cnt_q       <= 8'd0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      thr_q       <= thr_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Self-checking bench for seqdet_ctrl: directed vectors, corner sequences and
// randomized traffic compared against a stream-level reference model.
module tb_seqdet_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       bit_valid;
  logic       bit_out;
  logic       match;
  logic [7:0] match_cnt;
  logic       irq;
  logic       irq_clr;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  seqdet_ctrl_if #(.DATA_W(8)) bus ();

  seqdet_ctrl #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus.slave),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .bit_valid   (bit_valid),
    .bit_out     (bit_out),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of bits still to be emitted and a list of bits seen.
  int         m_pend[$];
  int         m_seen[$];
  logic       m_bv, m_bo, m_match, m_irq;
  logic [7:0] m_cnt, m_pat, m_thr;
  int         m_len;

  task automatic model_edge();
    int  accept, idle, hit, n, set_irq;
    logic [7:0] w;
    if (rst) begin
      m_pend.delete(); m_seen.delete();
      m_bv = 1'b0; m_bo = 1'b0; m_match = 1'b0; m_cnt = 8'd0; m_irq = 1'b0;
      m_pat = 8'h12; m_len = 5; m_thr = 8'd0;
      return;
    end
    accept  = (bus.in_valid && (m_pend.size() == 0)) ? 1 : 0;
    idle    = m_bv ? 0 : 1;
    hit     = 0;
    set_irq = 0;
    if (m_bv) begin
      m_seen.push_back(int'(m_bo));
      if (m_seen.size() > 8) void'(m_seen.pop_front());
      n = m_seen.size();
      if (m_len > 0 && n >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (m_seen[n-1-k] != int'(m_pat[k])) hit = 0;
      end
    end
    m_match = (hit != 0);
    if (hit != 0 && m_cnt != 8'd255) begin
      m_cnt = m_cnt + 8'd1;
      if (m_thr != 8'd0 && m_cnt == m_thr) set_irq = 1;
    end
    if (set_irq != 0) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
    if (cfg_we && idle != 0) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
      m_thr = cfg_thresh;
      m_seen.delete();
      m_cnt = 8'd0;
      m_irq = 1'b0;
    end
    if (m_pend.size() > 0) begin
      m_bo = m_pend.pop_front();
      m_bv = 1'b1;
    end else if (accept != 0) begin
      w = bus.in_data;
      for (int b = 7; b >= 0; b--) m_pend.push_back(int'(w[b]));
      m_bo = m_pend.pop_front();
      m_bv = 1'b1;
    end else begin
      m_bv = 1'b0;
      m_bo = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("bit_valid", int'(bit_valid), int'(m_bv));
    chk("bit_out",   int'(bit_out),   int'(m_bo));
    chk("match",     int'(match),     int'(m_match));
    chk("match_cnt", int'(match_cnt), int'(m_cnt));
    chk("irq",       int'(irq),       int'(m_irq));
    chk("in_ready",  int'(bus.in_ready), (m_pend.size() == 0) ? 1 : 0);
    chk("busy",      int'(busy),      int'(m_bv));
  endtask

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       exp_bv;
    logic       exp_bo;
    logic       exp_match;
    logic [7:0] exp_cnt;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nm, mc, nbv, nbusy;

    tbl[0] = '{1'b1, 8'h92, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1};

    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    cfg_thresh = 8'd0; irq_clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_bit_valid", int'(bit_valid), 0);
    chk("reset_match_cnt", int'(match_cnt), 0);
    chk("reset_in_ready",  int'(bus.in_ready), 1);
    chk("reset_busy",      int'(busy), 0);
    chk("reset_irq",       int'(irq), 0);

    // Default pattern 10010 on word 1001_0010, with ignored data while not ready.
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = tbl[i].in_valid;
      bus.in_data  = tbl[i].in_data;
      tick();
      chk($sformatf("vec%0d_bit_valid", i), int'(bit_valid), int'(tbl[i].exp_bv));
      chk($sformatf("vec%0d_bit_out", i),   int'(bit_out),   int'(tbl[i].exp_bo));
      chk($sformatf("vec%0d_match", i),     int'(match),     int'(tbl[i].exp_match));
      chk($sformatf("vec%0d_match_cnt", i), int'(match_cnt), int'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_in_ready", i),  int'(bus.in_ready), int'(tbl[i].exp_ready));
    end

    // Config write during SHIFT is ignored; count keeps accumulating.
    bus.in_valid = 1'b1; bus.in_data = 8'h92; tick(); bus.in_valid = 1'b0;
    tick(); tick();
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd1; cfg_thresh = 8'd1;
    tick(); cfg_we = 1'b0;
    for (int c = 5; c <= 10; c++) tick();
    chk("shift_cfg_match_cnt", int'(match_cnt), 4);
    chk("shift_cfg_irq",       int'(irq), 0);

    // Reset mid-word discards the word and restores defaults.
    bus.in_valid = 1'b1; bus.in_data = 8'h92; tick(); bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_bit_valid", int'(bit_valid), 0);
    chk("midrst_match_cnt", int'(match_cnt), 0);
    chk("midrst_in_ready",  int'(bus.in_ready), 1);
    nbv = 0;
    for (int c = 0; c < 3; c++) begin tick(); nbv += int'(bit_valid); end
    chk("midrst_no_bits", nbv, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'h92; tick(); bus.in_valid = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    chk("midrst_default_pattern_cnt", int'(match_cnt), 2);

    // Back-to-back words 8'hFF, 8'h00 stream without a gap.
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; tick(); bus.in_data = 8'h00;
    nbv = int'(bit_valid); nbusy = int'(busy);
    for (int c = 2; c <= 17; c++) begin
      tick();
      if (c == 8) chk("b2b_ready_T8", int'(bus.in_ready), 1);
      if (c == 9) bus.in_valid = 1'b0;
      if (c <= 16) begin nbv += int'(bit_valid); nbusy += int'(busy); end
      if (c == 17) chk("b2b_bit_valid_T17", int'(bit_valid), 0);
    end
    chk("b2b_bit_valid_cycles", nbv, 16);
    chk("b2b_busy_cycles", nbusy, 16);

    // Single-bit pattern with threshold 3, set/clear collision, then clear.
    cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_thresh = 8'd3;
    tick(); cfg_we = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h07; tick(); bus.in_valid = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      irq_clr = (c == 9 || c == 11);
      tick();
      chk($sformatf("thr_match_T%0d", c), int'(match), (c >= 7 && c <= 9) ? 1 : 0);
      if (c == 9)  chk("thr_cnt_T9", int'(match_cnt), 3);
      if (c == 9)  chk("thr_irq_T9_set_wins", int'(irq), 1);
      if (c == 10) chk("thr_irq_T10", int'(irq), 1);
      if (c == 11) chk("thr_irq_T11_cleared", int'(irq), 0);
    end
    irq_clr = 1'b0;

    // Pattern spanning a word boundary: 8'h09 then 8'h00.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h09; tick(); bus.in_data = 8'h00;
    nm = 0; mc = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (c == 9) bus.in_valid = 1'b0;
      if (match) begin nm++; mc = c; end
    end
    chk("span_match_count", nm, 1);
    chk("span_match_cycle", mc, 10);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      cfg_we       = ($urandom_range(0, 24) == 0);
      cfg_pattern  = 8'($urandom_range(0, 255));
      cfg_len      = 4'($urandom_range(0, 15));
      cfg_thresh   = 8'($urandom_range(0, 6));
      irq_clr      = ($urandom_range(0, 11) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0; bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
